// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter and its round-robin picker.
package mul_arb_pkg;

  localparam int OP_W       = 16;
  localparam int PROD_W     = 2 * OP_W;
  localparam int MUL_CYCLES = 16;
  localparam int BOOT_CYC   = MUL_CYCLES + 2;
  localparam int BOOT_CNT_W = $clog2(BOOT_CYC);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping at N-1.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential 16x16 multiplier among NUM_REQ requesters with round-robin grant.
// Optional WAIT watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 24
) (
  input  logic                    clockMul,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*OP_W-1:0] op_a,
  input  logic [NUM_REQ*OP_W-1:0] op_b,
  output logic [NUM_REQ-1:0]      ack,
  output logic [PROD_W-1:0]       result,
  output logic                    err,
  output logic                    busy,
  output logic                    mul_start,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  input  logic                    mul_done,
  input  logic [PROD_W-1:0]       mul_prod
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_chk
    $error("mul_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  state_e                state_q, state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d;
  logic [OP_W-1:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                  mul_start_q, mul_start_d;
  logic                  done_q, done_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [PROD_W-1:0]     result_q, result_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_vld;
  logic [OP_W-1:0]       sel_a, sel_b;
  logic                  mul_cmpl;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
`endif

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_a = op_a[i*OP_W +: OP_W];
        sel_b = op_b[i*OP_W +: OP_W];
      end
    end
  end

  // done is a level from the multiplier; only its rising edge marks our op finishing.
  assign mul_cmpl = mul_done & ~done_q;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    done_d      = mul_done;
    ack_d       = '0;
    result_d    = result_q;
`ifdef MUL_ARB_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_CNT_W'(BOOT_CYC - 1)) begin
          boot_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (arb_vld) begin
          gnt_idx_d   = arb_idx;
          gnt_oh_d    = arb_gnt;
          mul_a_d     = sel_a;
          mul_b_d     = sel_b;
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        done_d  = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_cmpl) begin
          result_d = mul_prod;
          ack_d    = gnt_oh_q;
          state_d  = S_RESP;
        end
`ifdef MUL_ARB_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
          result_d = '0;
          ack_d    = gnt_oh_q;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        ptr_d = IDX_W'(rr_next(int'(gnt_idx_q), NUM_REQ));
`ifdef MUL_ARB_TIMEOUT_EN
        // A hung multiplier may still finish later; drain it before the next grant.
        state_d = err_q ? S_BOOT : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clockMul or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      result_q    <= result_d;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  always_ff @(posedge clockMul or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ack       = ack_q;
  assign result    = result_q;
  assign busy      = (state_q != S_IDLE);
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule
